// File: rtl/tlp_xcvr_pkg.sv
// Shared types for the PCIe TLP transceiver (receive and send sides).
// Holds the header field layouts, the fmt/type codes that are recognised, and the
// Action record passed between the TLP parser and the register/action FIFO.
package tlp_xcvr_pkg;

    // Combined {fmt[2:0], type[4:0]} codes of the TLPs that are decoded
    localparam logic [7:0] FT_MWR32 = 8'h40;   // 3DW header with data, memory write
    localparam logic [7:0] FT_MRD32 = 8'h00;   // 3DW header no data, memory read
    localparam logic [7:0] FT_CPLD  = 8'h4A;   // 3DW header with data, completion

    // Width of the channel (register) index carried in an Action
    localparam int CHAN_W = 4;

    // Header DW0: common to every TLP
    typedef struct packed {
        logic [2:0]  fmt;
        logic [4:0]  typ;
        logic [13:0] tc_attr;
        logic [9:0]  length;
    } tlp_dw0_t;

    // Header DW1 of a memory request
    typedef struct packed {
        logic [15:0] req_id;
        logic [7:0]  tag;
        logic [3:0]  last_be;
        logic [3:0]  first_be;
    } tlp_dw1_t;

    // Header DW2 of a 32-bit memory request
    typedef struct packed {
        logic [31:0] addr;
    } tlp_dw2_t;

    // Header DW2 of a completion
    typedef struct packed {
        logic [15:0] req_id;
        logic [7:0]  tag;
        logic        rsvd;
        logic [6:0]  lower_addr;
    } tlp_cpl_dw2_t;

    // Which kind of header is being parsed after DW0/DW1 were decoded
    typedef enum logic [1:0] {
        HK_WR  = 2'd0,
        HK_RD  = 2'd1,
        HK_CPL = 2'd2
    } hdr_kind_t;

    typedef enum logic {
        ACT_WRITE = 1'b0,
        ACT_READ  = 1'b1
    } act_kind_t;

    typedef struct packed {
        logic [15:0]       req_id;
        logic [7:0]        tag;
        logic [CHAN_W-1:0] chan;
    } RegRead;

    typedef struct packed {
        logic [CHAN_W-1:0] chan;
        logic [31:0]       data;
    } RegWrite;

    // Unified record for the action FIFO; fields unused by a kind are zero
    typedef struct packed {
        act_kind_t         kind;
        logic [15:0]       req_id;
        logic [7:0]        tag;
        logic [CHAN_W-1:0] chan;
        logic [31:0]       data;
    } Action;

    function automatic logic isRegWr(input logic [7:0] ft, input logic [9:0] len);
        return (ft == FT_MWR32) && (len == 10'd1);
    endfunction

    function automatic logic isRegRd(input logic [7:0] ft, input logic [9:0] len);
        return (ft == FT_MRD32) && (len == 10'd1);
    endfunction

    function automatic logic isCplD(input logic [7:0] ft);
        return (ft == FT_CPLD);
    endfunction

    function automatic Action mk_read(input RegRead r);
        Action a;
        a.kind   = ACT_READ;
        a.req_id = r.req_id;
        a.tag    = r.tag;
        a.chan   = r.chan;
        a.data   = '0;
        return a;
    endfunction

    function automatic Action mk_write(input RegWrite w);
        Action a;
        a.kind   = ACT_WRITE;
        a.req_id = '0;
        a.tag    = '0;
        a.chan   = w.chan;
        a.data   = w.data;
        return a;
    endfunction

endpackage

// File: rtl/tlp_recv.sv
// Receive side of the PCIe TLP transceiver.
// Parses 64-bit Avalon-ST RX beats: 1DW BAR writes/reads become Action records,
// CplD payload is passed straight through to the c2f pipe, everything else is dropped.
// Optional feature: define TLP_RECV_DROPCNT_EN to add dropCount_out, a saturating
// count of TLPs that were discarded or aborted.
module tlp_recv
    import tlp_xcvr_pkg::*;
#(
    parameter int CHAN_LSB  = 2,
    parameter int CPL_MAXDW = 32
)(
    input  logic        pcieClk_in,
    input  logic        pcieReset_in,
    input  logic [63:0] rxData_in,
    input  logic        rxValid_in,
    output logic        rxReady_out,
    input  logic        rxSOP_in,
    input  logic        rxEOP_in,
    output Action       actData_out,
    output logic        actValid_out,
    input  logic        actReady_in,
    output logic [63:0] c2fData_out,
    output logic        c2fValid_out,
    input  logic        c2fReady_in
`ifdef TLP_RECV_DROPCNT_EN
    ,
    output logic [15:0] dropCount_out
`endif
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_HDR1     = 3'd1;
    localparam logic [2:0] S_WR_DATA  = 3'd2;
    localparam logic [2:0] S_CPL_DATA = 3'd3;
    localparam logic [2:0] S_DISCARD  = 3'd4;

    logic [2:0]        r_state;
    logic [2:0]        w_state_next;
    hdr_kind_t         r_kind;
    hdr_kind_t         w_kind_next;
    logic [15:0]       r_req_id;
    logic [7:0]        r_tag;
    logic [3:0]        r_first_be;
    logic [CHAN_W-1:0] r_chan;
    logic              r_act_valid;
    Action             r_act_data;

    logic              w_acc;
    logic [7:0]        w_ft;
    logic [9:0]        w_len;
    tlp_dw1_t          w_dw1;
    logic [CHAN_W-1:0] w_addr_chan;
    logic              w_cpl_len_ok;
    logic              w_hdr_load;
    logic              w_chan_load;
    logic              w_emit;
    Action             w_act_next;
    RegRead            w_rd;
    RegWrite           w_wr;

    assign w_acc       = rxValid_in & rxReady_out;
    assign w_ft        = rxData_in[31:24];
    assign w_len       = rxData_in[9:0];
    assign w_dw1       = rxData_in[63:32];
    assign w_addr_chan = rxData_in[CHAN_LSB +: CHAN_W];
    // Completion payload must be whole QWs, non-zero (zero encodes 1024) and within limit
    assign w_cpl_len_ok = (w_len != 10'd0) && !w_len[0] && (w_len <= 10'(CPL_MAXDW));

    // RX ready: blocked while an action is pending; follows the sink during payload
    always_comb begin
        case (r_state)
            S_CPL_DATA: rxReady_out = c2fReady_in;
            default:    rxReady_out = !r_act_valid;
        endcase
        if (pcieReset_in) begin
            rxReady_out = 1'b0;
        end
    end

    // Completion payload is a zero-latency pass-through of the RX beat
    assign c2fData_out  = rxData_in;
    assign c2fValid_out = (r_state == S_CPL_DATA) && rxValid_in && !pcieReset_in;

    assign actData_out  = r_act_data;
    assign actValid_out = r_act_valid;

    // Next-state decode; only accepted beats advance the parser
    always_comb begin
        w_state_next = r_state;
        w_kind_next  = r_kind;
        w_hdr_load   = 1'b0;
        w_chan_load  = 1'b0;
        w_emit       = 1'b0;
        w_rd.req_id  = r_req_id;
        w_rd.tag     = r_tag;
        w_rd.chan    = w_addr_chan;
        w_wr.chan    = w_addr_chan;
        w_wr.data    = rxData_in[63:32];
        w_act_next   = r_act_data;
        if (w_acc) begin
            case (r_state)
                S_IDLE: begin
                    if (rxSOP_in) begin
                        w_hdr_load = 1'b1;
                        if (rxEOP_in) begin
                            w_state_next = S_IDLE;
                        end else if (isRegWr(w_ft, w_len) && (w_dw1.last_be == 4'd0)) begin
                            w_state_next = S_HDR1;
                            w_kind_next  = HK_WR;
                        end else if (isRegRd(w_ft, w_len) && (w_dw1.last_be == 4'd0)) begin
                            w_state_next = S_HDR1;
                            w_kind_next  = HK_RD;
                        end else if (isCplD(w_ft) && w_cpl_len_ok) begin
                            w_state_next = S_HDR1;
                            w_kind_next  = HK_CPL;
                        end else begin
                            w_state_next = S_DISCARD;
                        end
                    end
                end
                S_HDR1: begin
                    case (r_kind)
                        HK_RD: begin
                            w_emit       = 1'b1;
                            w_act_next   = mk_read(w_rd);
                            w_state_next = rxEOP_in ? S_IDLE : S_DISCARD;
                        end
                        HK_WR: begin
                            if (rxData_in[2]) begin
                                // Unaligned address: the data DW shares this beat
                                w_emit       = (r_first_be != 4'd0);
                                w_act_next   = mk_write(w_wr);
                                w_state_next = rxEOP_in ? S_IDLE : S_DISCARD;
                            end else if (rxEOP_in) begin
                                w_state_next = S_IDLE;
                            end else begin
                                w_chan_load  = 1'b1;
                                w_state_next = S_WR_DATA;
                            end
                        end
                        default: begin
                            // Payload that does not start QW-aligned is not supported
                            if (rxEOP_in) begin
                                w_state_next = S_IDLE;
                            end else if (rxData_in[2]) begin
                                w_state_next = S_DISCARD;
                            end else begin
                                w_state_next = S_CPL_DATA;
                            end
                        end
                    endcase
                end
                S_WR_DATA: begin
                    w_wr.chan    = r_chan;
                    w_wr.data    = rxData_in[31:0];
                    w_emit       = (r_first_be != 4'd0);
                    w_act_next   = mk_write(w_wr);
                    w_state_next = rxEOP_in ? S_IDLE : S_DISCARD;
                end
                S_CPL_DATA, S_DISCARD: begin
                    if (rxEOP_in) begin
                        w_state_next = S_IDLE;
                    end
                end
                default: begin
                    w_state_next = S_IDLE;
                end
            endcase
        end
    end

    // Parser state and pending-action flag
    always_ff @(posedge pcieClk_in) begin
        if (pcieReset_in) begin
            r_state     <= S_IDLE;
            r_act_valid <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_emit) begin
                r_act_valid <= 1'b1;
            end else if (actReady_in) begin
                r_act_valid <= 1'b0;
            end
        end
    end

    // Header fields and action payload; no reset needed, qualified by state/valid
    always_ff @(posedge pcieClk_in) begin
        r_kind <= w_kind_next;
        if (w_hdr_load) begin
            r_req_id   <= w_dw1.req_id;
            r_tag      <= w_dw1.tag;
            r_first_be <= w_dw1.first_be;
        end
        if (w_chan_load) begin
            r_chan <= w_addr_chan;
        end
        if (w_emit) begin
            r_act_data <= w_act_next;
        end
    end

`ifdef TLP_RECV_DROPCNT_EN
    logic        w_drop;
    logic [15:0] r_drop_cnt;

    // A TLP is dropped when its last beat lands in discard or cuts a header short
    always_comb begin
        w_drop = 1'b0;
        if (w_acc && rxEOP_in) begin
            case (r_state)
                S_IDLE:    w_drop = rxSOP_in;
                S_DISCARD: w_drop = 1'b1;
                S_HDR1:    w_drop = (r_kind == HK_CPL) || ((r_kind == HK_WR) && !rxData_in[2]);
                default:   w_drop = 1'b0;
            endcase
        end
    end

    // Saturating drop counter
    always_ff @(posedge pcieClk_in) begin
        if (pcieReset_in) begin
            r_drop_cnt <= 16'd0;
        end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign dropCount_out = r_drop_cnt;
`endif

endmodule

// File: tb/tb_tlp_recv.sv
// Directed bench for tlp_recv: expected actions and c2f beats are queued when the
// stimulus is driven and compared when the DUT hands them over.
module tb_tlp_recv;
    import tlp_xcvr_pkg::*;

    logic        clk = 1'b0;
    logic        srst = 1'b1;
    logic [63:0] rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        rx_sop = 1'b0;
    logic        rx_eop = 1'b0;
    Action       act_data;
    logic        act_valid;
    logic        act_ready = 1'b1;
    logic [63:0] c2f_data;
    logic        c2f_valid;
    logic        c2f_ready = 1'b1;
`ifdef TLP_RECV_DROPCNT_EN
    logic [15:0] drop_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int n_act_seen = 0;
    int n_act_pushed = 0;
    int n_c2f_seen = 0;
    int n_c2f_pushed = 0;
    bit in_cpl = 1'b0;
    bit toggle_en = 1'b0;
    Action       exp_act[$];
    logic [63:0] exp_c2f[$];

    tlp_recv dut (
        .pcieClk_in   (clk),
        .pcieReset_in (srst),
        .rxData_in    (rx_data),
        .rxValid_in   (rx_valid),
        .rxReady_out  (rx_ready),
        .rxSOP_in     (rx_sop),
        .rxEOP_in     (rx_eop),
        .actData_out  (act_data),
        .actValid_out (act_valid),
        .actReady_in  (act_ready),
        .c2fData_out  (c2f_data),
        .c2fValid_out (c2f_valid),
        .c2fReady_in  (c2f_ready)
`ifdef TLP_RECV_DROPCNT_EN
        ,
        .dropCount_out(drop_cnt)
`endif
    );

    always #4 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic Action exp_action(input act_kind_t k, input logic [15:0] rid,
                                         input logic [7:0] tg, input logic [3:0] ch,
                                         input logic [31:0] d);
        Action a;
        a.kind   = k;
        a.req_id = rid;
        a.tag    = tg;
        a.chan   = ch;
        a.data   = d;
        return a;
    endfunction

    task automatic push_act(input Action a);
        exp_act.push_back(a);
        n_act_pushed++;
    endtask

    // Called and returns one time unit after a rising edge
    task automatic send_beat(input logic [63:0] d, input logic sop, input logic eop);
        int n;
        n = 0;
        rx_data  = d;
        rx_sop   = sop;
        rx_eop   = eop;
        rx_valid = 1'b1;
        @(negedge clk);
        while (rx_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            check("rx_accept_timeout", 64'(rx_ready), 64'd1);
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_sop   = 1'b0;
        rx_eop   = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Action monitor: one line per accepted action
    always @(negedge clk) begin
        if (act_valid === 1'b1 && act_ready === 1'b1) begin
            n_act_seen++;
            check("act_expected", 64'(exp_act.size() != 0), 64'd1);
            if (exp_act.size() != 0) begin
                Action e;
                e = exp_act.pop_front();
                $display("ACT  kind=%0d req=%h tag=%h chan=%0d data=%h", act_data.kind,
                         act_data.req_id, act_data.tag, act_data.chan, act_data.data);
                check("act_data", 64'(act_data), 64'(e));
            end
        end
    end

    // c2f monitor: one line per payload transfer, plus ready mirroring during payload
    always @(negedge clk) begin
        if (c2f_valid === 1'b1 && c2f_ready === 1'b1) begin
            n_c2f_seen++;
            check("c2f_expected", 64'(exp_c2f.size() != 0), 64'd1);
            if (exp_c2f.size() != 0) begin
                logic [63:0] e;
                e = exp_c2f.pop_front();
                $display("C2F  data=%h", c2f_data);
                check("c2f_data", c2f_data, e);
            end
        end
        if (in_cpl && rx_valid) begin
            check("rx_ready_mirror", 64'(rx_ready), 64'(c2f_ready));
        end
    end

    // Back-pressure on the c2f sink while enabled
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (toggle_en) c2f_ready = ~c2f_ready;
        end
    end

    initial begin
        Action rd;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_rx_ready", 64'(rx_ready), 64'd0);
        check("reset_act_valid", 64'(act_valid), 64'd0);
        check("reset_c2f_valid", 64'(c2f_valid), 64'd0);
        @(posedge clk);
        #1;
        srst = 1'b0;
        @(negedge clk);
        check("idle_rx_ready", 64'(rx_ready), 64'd1);
`ifdef TLP_RECV_DROPCNT_EN
        check("drop_cnt_reset", 64'(drop_cnt), 64'd0);
`endif
        idle_cycles(1);

        // MWr32, unaligned address: data in the second beat
        push_act(exp_action(ACT_WRITE, 16'h0, 8'h0, 4'd3, 32'hCAFEF00D));
        send_beat(64'h0100010F_40000001, 1'b1, 1'b0);
        send_beat(64'hCAFEF00D_0000000C, 1'b0, 1'b1);

        // MWr32, QW-aligned address: data in a third beat
        push_act(exp_action(ACT_WRITE, 16'h0, 8'h0, 4'd4, 32'h12345678));
        send_beat(64'h0100010F_40000001, 1'b1, 1'b0);
        send_beat(64'h00000000_00000010, 1'b0, 1'b0);
        send_beat(64'h00000000_12345678, 1'b0, 1'b1);

        // MWr32 with all byte enables off: consumed, no action
        send_beat(64'h01000100_40000001, 1'b1, 1'b0);
        send_beat(64'h55555555_00000014, 1'b0, 1'b1);
        idle_cycles(2);

        // MRd32 with the action FIFO stalled for 4 cycles
        act_ready = 1'b0;
        rd = exp_action(ACT_READ, 16'h0100, 8'h05, 4'd3, 32'h0);
        push_act(rd);
        send_beat(64'h0100050F_00000001, 1'b1, 1'b0);
        send_beat(64'h00000000_0000000C, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("pend_act_valid", 64'(act_valid), 64'd1);
            check("pend_act_data", 64'(act_data), 64'(rd));
            check("pend_rx_ready", 64'(rx_ready), 64'd0);
            @(posedge clk);
            #1;
        end
        act_ready = 1'b1;
        idle_cycles(2);

        // 4DW MWr is discarded, following MRd32 still decoded
        send_beat(64'h0100010F_60000001, 1'b1, 1'b0);
        send_beat(64'h00000000_00000001, 1'b0, 1'b0);
        send_beat(64'h00000000_AAAAAAAA, 1'b0, 1'b1);
        @(negedge clk);
`ifdef TLP_RECV_DROPCNT_EN
        check("drop_cnt_4dw", 64'(drop_cnt), 64'd1);
`endif
        check("act_none_after_4dw", 64'(act_valid), 64'd0);
        @(posedge clk);
        #1;
        push_act(exp_action(ACT_READ, 16'h0200, 8'h07, 4'd8, 32'h0));
        send_beat(64'h0200070F_00000001, 1'b1, 1'b0);
        send_beat(64'h00000000_00000020, 1'b0, 1'b1);

        // Aligned MWr32 whose EOP arrives before the data: aborted
        send_beat(64'h0100010F_40000001, 1'b1, 1'b0);
        send_beat(64'h00000000_00000010, 1'b0, 1'b1);
        idle_cycles(3);
`ifdef TLP_RECV_DROPCNT_EN
        @(negedge clk);
        check("drop_cnt_abort", 64'(drop_cnt), 64'd2);
        @(posedge clk);
        #1;
`endif

        // CplD len=32: 16 payload QWs with the sink toggling ready
        send_beat(64'h00000080_4A000020, 1'b1, 1'b0);
        send_beat(64'hDEADBEEF_01000500, 1'b0, 1'b0);
        in_cpl    = 1'b1;
        toggle_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            logic [63:0] d;
            d = {16'hC2F0, 16'(i), ~32'(i)};
            exp_c2f.push_back(d);
            n_c2f_pushed++;
            send_beat(d, 1'b0, (i == 15));
        end
        in_cpl    = 1'b0;
        toggle_en = 1'b0;
        c2f_ready = 1'b1;
        idle_cycles(2);

        // Reset pulsed after the sixth payload QW of a CplD
        send_beat(64'h00000080_4A000020, 1'b1, 1'b0);
        send_beat(64'hDEADBEEF_01000500, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            logic [63:0] d;
            d = {16'h5EED, 16'(i), 32'(i) * 32'h01010101};
            exp_c2f.push_back(d);
            n_c2f_pushed++;
            send_beat(d, 1'b0, 1'b0);
        end
        rx_data  = 64'hBAD0BAD0_BAD0BAD0;
        rx_valid = 1'b1;
        srst     = 1'b1;
        @(negedge clk);
        check("rst_c2f_valid", 64'(c2f_valid), 64'd0);
        check("rst_rx_ready", 64'(rx_ready), 64'd0);
        @(posedge clk);
        #1;
        srst     = 1'b0;
        rx_valid = 1'b0;
        @(negedge clk);
        check("post_rst_act_valid", 64'(act_valid), 64'd0);
        check("post_rst_rx_ready", 64'(rx_ready), 64'd1);
        @(posedge clk);
        #1;
        send_beat(64'hBAD0BAD0_BAD0BAD0, 1'b0, 1'b0);
        send_beat(64'hBAD1BAD1_BAD1BAD1, 1'b0, 1'b0);
        send_beat(64'hBAD2BAD2_BAD2BAD2, 1'b0, 1'b1);
        push_act(exp_action(ACT_WRITE, 16'h0, 8'h0, 4'd3, 32'h0BADF00D));
        send_beat(64'h0300090F_40000001, 1'b1, 1'b0);
        send_beat(64'h0BADF00D_0000000C, 1'b0, 1'b1);
        idle_cycles(5);
`ifdef TLP_RECV_DROPCNT_EN
        @(negedge clk);
        check("drop_cnt_final", 64'(drop_cnt), 64'd0);
        @(posedge clk);
        #1;
`endif

        // Everything queued was delivered, nothing extra
        @(negedge clk);
        check("act_queue_empty", 64'(exp_act.size()), 64'd0);
        check("c2f_queue_empty", 64'(exp_c2f.size()), 64'd0);
        check("act_count", 64'(n_act_seen), 64'(n_act_pushed));
        check("c2f_count", 64'(n_c2f_seen), 64'(n_c2f_pushed));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time limit
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
